// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready port and feeds the IF/ID register.
// Optional build macro MISALIGN_TRAP_EN: a misaligned redirect target halts fetch and sets a sticky error.
module fetch_unit #(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic                     redirect_jalr,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic [DATA_WIDTH-1:0]    rd1,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ready,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic                     instr_valid,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4,
  output logic                     misalign_err
);

  localparam logic [DATA_WIDTH-1:0]    NOP   = DATA_WIDTH'(32'h0000_0013);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR  = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] BIT0  = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LOW2  = ADDRESS_WIDTH'(3);

  typedef enum logic [2:0] {BOOT, REQ, HOLD, DISCARD, HALT} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic                     req_q, req_d;
  logic [DATA_WIDTH-1:0]    instr_q, instr_d;
  logic [DATA_WIDTH-1:0]    skid_q, skid_d;
  logic [ADDRESS_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;

  logic [ADDRESS_WIDTH-1:0] base;
  logic [ADDRESS_WIDTH-1:0] raw;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     trap;

  // Redirect target arithmetic wraps modulo the address width.
  always_comb begin
    base = redirect_jalr ? rd1[ADDRESS_WIDTH-1:0] : redirect_pc;
    raw  = base + ImmOp[ADDRESS_WIDTH-1:0];
    if (redirect_jalr) raw = raw & ~BIT0;
`ifdef MISALIGN_TRAP_EN
    target = raw;
    trap   = redirect && (raw[1:0] != 2'b00);
`else
    target = raw & ~LOW2;
    trap   = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    skid_d     = skid_q;
    pc_out_d   = pc_out_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    err_d      = err_q | trap;

    unique case (state_q)
      BOOT: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = trap ? HALT : REQ;
        end else begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          if (imem_ready) state_d = trap ? HALT : REQ;
          else            state_d = DISCARD;
        end else if (imem_ready) begin
          if (!stall) begin
            instr_d    = imem_rdata;
            pc_out_d   = pc_q;
            pc_plus4_d = pc_q + FOUR;
            valid_d    = 1'b1;
            pc_d       = pc_q + FOUR;
          end else begin
            skid_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = trap ? HALT : REQ;
        end else if (!stall) begin
          instr_d    = skid_q;
          pc_out_d   = pc_q;
          pc_plus4_d = pc_q + FOUR;
          valid_d    = 1'b1;
          pc_d       = pc_q + FOUR;
          state_d    = REQ;
        end
      end
      DISCARD: begin
        // The old request must still complete; its data is thrown away.
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end
        if (imem_ready) state_d = err_d ? HALT : REQ;
      end
      HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    req_d  = (state_d == REQ) || (state_d == DISCARD);
    addr_d = (state_d == DISCARD) ? addr_q : pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= NOP;
      skid_q     <= NOP;
      pc_out_q   <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      skid_q     <= skid_d;
      pc_out_q   <= pc_out_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = addr_q;
  assign instr        = instr_q;
  assign instr_valid  = valid_q;
  assign PC           = pc_out_q;
  assign PCPlus4      = pc_plus4_q;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences and a randomized
// run checked against an in-order instruction-stream model. Honors MISALIGN_TRAP_EN if defined.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic        redirect_jalr;
   logic [31:0] redirect_pc;
   logic [31:0] ImmOp;
   logic [31:0] rd1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        misalign_err;

   int testsRun    = 0;
   int testsFailed = 0;

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_jalr(redirect_jalr), .redirect_pc(redirect_pc), .ImmOp(ImmOp), .rd1(rd1),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid), .PC(PC),
      .PCPlus4(PCPlus4), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   // Instruction memory content is a fixed scramble of the address.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
   endfunction

   assign imem_rdata = memWord(imem_addr);

   function automatic logic [31:0] modelTarget(input logic jalr, input logic [31:0] rpc,
                                               input logic [31:0] imm, input logic [31:0] r1);
      logic [31:0] t;
      t = (jalr ? r1 : rpc) + imm;
      if (jalr) t = t & ~32'h1;
`ifndef MISALIGN_TRAP_EN
      t = t & ~32'h3;
`endif
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic rdy, input logic rd, input logic jalr,
                                input logic [31:0] rpc, input logic [31:0] imm, input logic [31:0] r1);
      stall         = st;
      imem_ready    = rdy;
      redirect      = rd;
      redirect_jalr = jalr;
      redirect_pc   = rpc;
      ImmOp         = imm;
      rd1           = r1;
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Holds reset for two cycles, checks the reset state, and releases on a falling edge.
   task automatic doReset;
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      repeat (2) tick;
      checkOutput("reset imem_req", 32'(imem_req), 32'h0);
      checkOutput("reset instr", instr, 32'h0000_0013);
      checkOutput("reset instr_valid", 32'(instr_valid), 32'h0);
      checkOutput("reset PC", PC, 32'h0);
      checkOutput("reset PCPlus4", PCPlus4, 32'h0);
      checkOutput("reset misalign_err", 32'(misalign_err), 32'h0);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        stall;
      logic        ready;
      logic        redirect;
      logic        jalr;
      logic [31:0] rpc;
      logic [31:0] imm;
      logic [31:0] r1;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic [31:0] expPc;
   } vector_t;

   vector_t vecs[$];

   task automatic addVec(input logic st, input logic rdy, input logic rd, input logic jalr,
                         input logic [31:0] rpc, input logic [31:0] imm, input logic [31:0] r1,
                         input logic eReq, input logic [31:0] eAddr, input logic eValid, input logic [31:0] ePc);
      vector_t v;
      v = '{st, rdy, rd, jalr, rpc, imm, r1, eReq, eAddr, eValid, ePc};
      vecs.push_back(v);
   endtask

   task automatic checkFetch(input string tag, input logic [31:0] expPc);
      checkOutput({tag, " valid"}, 32'(instr_valid), 32'h1);
      checkOutput({tag, " PC"}, PC, expPc);
      checkOutput({tag, " instr"}, instr, memWord(expPc));
      checkOutput({tag, " PCPlus4"}, PCPlus4, expPc + 32'h4);
   endtask

   initial begin
      logic        st, rdy, rd, jalr;
      logic [31:0] rpc, imm, r1;
      logic        preValid, preReq;
      logic [31:0] prePc, preInstr, prePlus4, preAddr;
      logic [31:0] expNextPc;
      int          consumed;
      int          idle;

      // Cycle-by-cycle vectors starting from the first edge after reset release.
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h0,   0, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h4,   1, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h8,   1, 32'h4);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'hC,   1, 32'h8);
      addVec(1, 1, 0, 0, 32'h0,   32'h0,        32'h0,   0, 32'h0,   1, 32'h8);
      addVec(1, 1, 0, 0, 32'h0,   32'h0,        32'h0,   0, 32'h0,   1, 32'h8);
      addVec(1, 1, 0, 0, 32'h0,   32'h0,        32'h0,   0, 32'h0,   1, 32'h8);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h10,  1, 32'hC);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h14,  1, 32'h10);
      addVec(0, 1, 1, 0, 32'h40,  32'hFFFF_FFF8, 32'h0,  1, 32'h38,  0, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h3C,  1, 32'h38);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h40,  1, 32'h3C);
      addVec(0, 1, 1, 1, 32'h0,   32'h4,        32'h101, 1, 32'h104, 0, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h108, 1, 32'h104);
      addVec(0, 0, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h108, 0, 32'h0);
      addVec(1, 0, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h108, 0, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h10C, 1, 32'h108);
      addVec(0, 0, 1, 0, 32'h200, 32'h10,       32'h0,   1, 32'h10C, 0, 32'h0);
      addVec(0, 0, 1, 0, 32'h300, 32'h0,        32'h0,   1, 32'h10C, 0, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h300, 0, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h304, 1, 32'h300);
      addVec(1, 1, 0, 0, 32'h0,   32'h0,        32'h0,   0, 32'h0,   1, 32'h300);
      addVec(1, 1, 1, 0, 32'h80,  32'h0,        32'h0,   1, 32'h80,  0, 32'h0);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h84,  1, 32'h80);
      addVec(0, 1, 0, 0, 32'h0,   32'h0,        32'h0,   1, 32'h88,  1, 32'h84);

      doReset();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].stall, vecs[i].ready, vecs[i].redirect, vecs[i].jalr,
                       vecs[i].rpc, vecs[i].imm, vecs[i].r1);
         tick;
         checkOutput($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(vecs[i].expReq));
         if (vecs[i].expReq) checkOutput($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].expValid));
         if (vecs[i].expValid) begin
            checkOutput($sformatf("vec%0d PC", i), PC, vecs[i].expPc);
            checkOutput($sformatf("vec%0d instr", i), instr, memWord(vecs[i].expPc));
            checkOutput($sformatf("vec%0d PCPlus4", i), PCPlus4, vecs[i].expPc + 32'h4);
         end
      end

      // Address wrap from the top of the space back to zero.
      applyStimulus(0, 1, 1, 0, 32'hFFFF_FFF0, 32'h8, 32'h0);
      tick;
      checkOutput("wrap first addr", imem_addr, 32'hFFFF_FFF8);
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
      tick;
      checkFetch("wrap fetch0", 32'hFFFF_FFF8);
      tick;
      checkFetch("wrap fetch1", 32'hFFFF_FFFC);
      checkOutput("wrap addr zero", imem_addr, 32'h0);
      tick;
      checkFetch("wrap fetch2", 32'h0);

`ifdef MISALIGN_TRAP_EN
      // Misaligned target halts fetching until reset.
      applyStimulus(0, 1, 1, 0, 32'h100, 32'h2, 32'h0);
      tick;
      checkOutput("trap misalign_err", 32'(misalign_err), 32'h1);
      checkOutput("trap instr_valid", 32'(instr_valid), 32'h0);
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("trap halt req%0d", k), 32'(imem_req), 32'h0);
         tick;
      end
      checkOutput("trap sticky", 32'(misalign_err), 32'h1);
`else
      // Misaligned target is silently aligned down.
      applyStimulus(0, 1, 1, 0, 32'h40, 32'h2, 32'h0);
      tick;
      checkOutput("align addr", imem_addr, 32'h40);
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
      tick;
      checkFetch("align fetch", 32'h40);
      checkOutput("align misalign_err", 32'(misalign_err), 32'h0);
`endif

      // Reset in the middle of a pending request abandons it.
      applyStimulus(0, 0, 1, 0, 32'h500, 32'h0, 32'h0);
      tick;
      applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      tick;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset imem_req", 32'(imem_req), 32'h0);
      checkOutput("midreset misalign_err", 32'(misalign_err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 1, 0, 0, 32'h0, 32'h0, 32'h0);
      tick;
      checkOutput("midreset first req", 32'(imem_req), 32'h1);
      checkOutput("midreset first addr", imem_addr, 32'h0);
      tick;
      checkFetch("midreset fetch0", 32'h0);

      // Randomized run against an in-order consumption model.
      doReset();
      expNextPc = 32'h0;
      consumed  = 0;
      idle      = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         st   = ($urandom_range(0, 99) < 25);
         rdy  = ($urandom_range(0, 99) < 60);
         rd   = ($urandom_range(0, 99) < 4);
         jalr = 1'($urandom_range(0, 1));
         rpc  = $urandom() & 32'hFFFF_FFFC;
         imm  = 32'(($urandom_range(0, 63) - 32) * 4);
         r1   = ($urandom() & 32'hFFFF_FFFC) | 32'h1;
         applyStimulus(st, rdy, rd, jalr, rpc, imm, r1);
         preValid = instr_valid;
         prePc    = PC;
         preInstr = instr;
         prePlus4 = PCPlus4;
         preReq   = imem_req;
         preAddr  = imem_addr;
         tick;
         if (rd) begin
            expNextPc = modelTarget(jalr, rpc, imm, r1);
            checkOutput("rnd flush valid", 32'(instr_valid), 32'h0);
            idle = 0;
         end else if (preValid && !st) begin
            checkOutput("rnd order PC", prePc, expNextPc);
            checkOutput("rnd instr", preInstr, memWord(prePc));
            checkOutput("rnd PCPlus4", prePlus4, prePc + 32'h4);
            expNextPc = expNextPc + 32'h4;
            consumed++;
            idle = 0;
         end else if (!st) begin
            idle++;
         end
         if (preReq && !rdy) begin
            checkOutput("rnd req held", 32'(imem_req), 32'h1);
            checkOutput("rnd addr held", imem_addr, preAddr);
         end
         if (idle > 40) begin
            checkOutput("rnd liveness idle cycles", 32'(idle), 32'h0);
            idle = 0;
         end
      end
      checkOutput("rnd enough consumed", 32'(consumed > 300), 32'h1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
